// File: rtl/cpu_load_store_unit_pkg.sv
// Shared definitions for the CPU load/store unit: access size codes,
// FSM state encoding and the misalignment test used by the datapath.
package cpu_load_store_unit_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'd0;
  localparam logic [1:0] SIZE_HALF    = 2'd1;
  localparam logic [1:0] SIZE_WORD    = 2'd2;
  localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    LSU_IDLE  = 3'd0,
    LSU_ACC0  = 3'd1,
    LSU_GAP   = 3'd2,
    LSU_ACC1  = 3'd3,
    LSU_RESP  = 3'd4,
    LSU_DRAIN = 3'd5
  } lsu_state_e;

  // An access is split when its last byte falls past lane 3 of the first word.
  function automatic logic is_split(input logic [1:0] off, input logic [1:0] size);
    logic [3:0] span;
    span = {2'b00, off} + (4'd1 << size);
    return span > 4'd4;
  endfunction

endpackage

// File: rtl/cpu_lsu_align.sv
// Lane alignment for the load/store unit: byte masks and lane-shifted store
// data for both word accesses, plus extraction and extension of load data
// from the pair of fetched words.
module cpu_lsu_align
  import cpu_load_store_unit_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] lo_word,
  input  logic [31:0] hi_word,
  output logic        split,
  output logic [3:0]  mask0,
  output logic [3:0]  mask1,
  output logic [31:0] data0,
  output logic [31:0] data1,
  output logic [31:0] ld_data
);

  logic [3:0]         nbytes;
  logic [7:0]         lanes;
  logic [7:0]         lanes_sh;
  logic [63:0]        pair;
  logic [31:0]        raw;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;
  logic signed [31:0] ext_s;

  // Masks span two words: low nibble is the first access, high nibble the second.
  always_comb begin
    nbytes   = 4'd1 << size;
    lanes    = (8'd1 << nbytes) - 8'd1;
    lanes_sh = lanes << off;
    split    = is_split(off, size);
    mask0    = lanes_sh[3:0];
    mask1    = lanes_sh[7:4];
    data0    = wdata << {off, 3'b000};
    data1    = (off == 2'd0) ? 32'd0 : (wdata >> {(3'd4 - {1'b0, off}), 3'b000});
  end

  // Load bytes start at lane off of the first word and continue into the second.
  always_comb begin
    pair    = {hi_word, lo_word};
    raw     = pair[{off, 3'b000} +: 32];
    byte_s  = raw[7:0];
    half_s  = raw[15:0];
    ext_s   = '0;
    ld_data = raw;
    unique case (size)
      SIZE_BYTE: begin
        ext_s   = byte_s;
        ld_data = is_unsigned ? {24'd0, raw[7:0]} : ext_s;
      end
      SIZE_HALF: begin
        ext_s   = half_s;
        ld_data = is_unsigned ? {16'd0, raw[15:0]} : ext_s;
      end
      default: ld_data = raw;
    endcase
  end

endmodule

// File: rtl/cpu_load_store_unit.sv
// CPU load/store front end. Turns one byte/half/word load or store into one
// or two word-aligned memory transactions with byte enables, then returns
// the lane-shifted, extended load result with a one-cycle done pulse.
module cpu_load_store_unit
  import cpu_load_store_unit_pkg::*;
#(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        is_store,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        fault,
  output logic        mem_rd_req,
  output logic        mem_wr_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_out,
  output logic [3:0]  mem_data_mask,
  input  logic [31:0] mem_data_in,
  input  logic        mem_done
);

  lsu_state_e  state, state_n;
  logic        op_store, op_uns;
  logic [1:0]  op_size;
  logic [31:0] op_addr, op_wdata;
  logic [31:0] lo_buf, hi_buf;

  logic        rd_n, wr_n, done_n, fault_n, cap_op;
  logic [31:0] addr_n, dout_n, rdata_n, lo_n, hi_n;
  logic [3:0]  mask_n;

  logic        idle, a_uns, split, bad;
  logic [1:0]  a_off, a_size;
  logic [31:0] a_wdata, lo_word, hi_word;
  logic [3:0]  mask0, mask1;
  logic [31:0] data0, data1, ld_data;

  // In IDLE the live operands drive alignment; afterwards the captured copy does.
  assign idle    = (state == LSU_IDLE);
  assign a_off   = idle ? addr[1:0]   : op_addr[1:0];
  assign a_size  = idle ? size        : op_size;
  assign a_uns   = idle ? is_unsigned : op_uns;
  assign a_wdata = idle ? wdata       : op_wdata;
  assign lo_word = (state == LSU_ACC0) ? mem_data_in : lo_buf;
  assign hi_word = (state == LSU_ACC1) ? mem_data_in : hi_buf;
  assign bad     = (a_size == SIZE_ILLEGAL) || (split && !SPLIT_MISALIGNED);

  cpu_lsu_align u_align (
    .off         (a_off),
    .size        (a_size),
    .is_unsigned (a_uns),
    .wdata       (a_wdata),
    .lo_word     (lo_word),
    .hi_word     (hi_word),
    .split       (split),
    .mask0       (mask0),
    .mask1       (mask1),
    .data0       (data0),
    .data1       (data1),
    .ld_data     (ld_data)
  );

  // Next-state and next-output logic; the bus is only re-raised once mem_done is low.
  always_comb begin
    state_n = state;
    rd_n    = mem_rd_req;
    wr_n    = mem_wr_req;
    addr_n  = mem_addr;
    dout_n  = mem_data_out;
    mask_n  = mem_data_mask;
    rdata_n = rdata;
    done_n  = 1'b0;
    fault_n = 1'b0;
    lo_n    = lo_buf;
    hi_n    = hi_buf;
    cap_op  = 1'b0;
    unique case (state)
      LSU_IDLE: begin
        if (req) begin
          cap_op = 1'b1;
          if (bad) begin
            state_n = LSU_RESP;
            done_n  = 1'b1;
            fault_n = 1'b1;
            rdata_n = '0;
          end else begin
            state_n = LSU_ACC0;
            rd_n    = !is_store;
            wr_n    = is_store;
            addr_n  = {addr[31:2], 2'b00};
            mask_n  = mask0;
            dout_n  = is_store ? data0 : '0;
          end
        end
      end
      LSU_ACC0: begin
        if (mem_done) begin
          lo_n = mem_data_in;
          rd_n = 1'b0;
          wr_n = 1'b0;
          if (split) begin
            state_n = LSU_GAP;
          end else begin
            state_n = LSU_RESP;
            done_n  = 1'b1;
            rdata_n = op_store ? '0 : ld_data;
          end
        end
      end
      LSU_GAP: begin
        if (!mem_done) begin
          state_n = LSU_ACC1;
          rd_n    = !op_store;
          wr_n    = op_store;
          addr_n  = {op_addr[31:2], 2'b00} + 32'd4;
          mask_n  = mask1;
          dout_n  = op_store ? data1 : '0;
        end
      end
      LSU_ACC1: begin
        if (mem_done) begin
          hi_n    = mem_data_in;
          rd_n    = 1'b0;
          wr_n    = 1'b0;
          state_n = LSU_RESP;
          done_n  = 1'b1;
          rdata_n = op_store ? '0 : ld_data;
        end
      end
      LSU_RESP:  state_n = mem_done ? LSU_DRAIN : LSU_IDLE;
      LSU_DRAIN: if (!mem_done) state_n = LSU_IDLE;
      default:   state_n = LSU_IDLE;
    endcase
  end

  // Control state and all visible outputs, cleared by the active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= LSU_IDLE;
      mem_rd_req    <= 1'b0;
      mem_wr_req    <= 1'b0;
      mem_addr      <= '0;
      mem_data_out  <= '0;
      mem_data_mask <= '0;
      rdata         <= '0;
      done          <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state         <= state_n;
      mem_rd_req    <= rd_n;
      mem_wr_req    <= wr_n;
      mem_addr      <= addr_n;
      mem_data_out  <= dout_n;
      mem_data_mask <= mask_n;
      rdata         <= rdata_n;
      done          <= done_n;
      fault         <= fault_n;
    end
  end

  // Operand copy and fetched-word buffers; only ever read after being written.
  always_ff @(posedge clk) begin
    if (cap_op) begin
      op_store <= is_store;
      op_uns   <= is_unsigned;
      op_size  <= size;
      op_addr  <= addr;
      op_wdata <= wdata;
    end
    lo_buf <= lo_n;
    hi_buf <= hi_n;
  end

endmodule

// File: tb/tb_cpu_load_store_unit.sv
// Directed bench for cpu_load_store_unit with a D=2 memory model.
module tb_cpu_load_store_unit;

  logic        clk = 1'b0;
  logic        rst, rst_nf;
  logic        req, req_nf, is_store, is_unsigned;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [31:0] rdata, mem_addr, mem_data_out, mem_data_in;
  logic        done, fault, mem_rd_req, mem_wr_req, mem_done;
  logic [3:0]  mem_data_mask;

  logic [31:0] rdata_nf, addr_nf, dout_nf;
  logic        done_nf, fault_nf, rd_nf, wr_nf;
  logic [3:0]  mask_nf;
  logic [31:0] zero_w = 32'd0;
  logic        zero_b = 1'b0;

  always #5 clk = ~clk;

  cpu_load_store_unit #(.SPLIT_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst(rst), .req(req), .is_store(is_store), .size(size),
    .is_unsigned(is_unsigned), .addr(addr), .wdata(wdata), .rdata(rdata),
    .done(done), .fault(fault), .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
    .mem_addr(mem_addr), .mem_data_out(mem_data_out), .mem_data_mask(mem_data_mask),
    .mem_data_in(mem_data_in), .mem_done(mem_done)
  );

  cpu_load_store_unit #(.SPLIT_MISALIGNED(1'b0)) dut_nf (
    .clk(clk), .rst(rst_nf), .req(req_nf), .is_store(is_store), .size(size),
    .is_unsigned(is_unsigned), .addr(addr), .wdata(wdata), .rdata(rdata_nf),
    .done(done_nf), .fault(fault_nf), .mem_rd_req(rd_nf), .mem_wr_req(wr_nf),
    .mem_addr(addr_nf), .mem_data_out(dout_nf), .mem_data_mask(mask_nf),
    .mem_data_in(zero_w), .mem_done(zero_b)
  );

  // ---------------- memory model (D = 2) ----------------
  typedef struct packed {
    logic        we;
    logic [31:0] a;
    logic [3:0]  m;
    logic [31:0] d;
  } acc_t;

  logic [7:0]  mem [logic [31:0]];
  acc_t        log_q [$];
  int          cnt = 0;
  int          viol = 0;
  logic        prev_req = 1'b0;
  logic [67:0] prev_bus = '0;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 4; k++)
      if (mem.exists(a + 32'(k))) r[8*k +: 8] = mem[a + 32'(k)];
    return r;
  endfunction

  task automatic put_word(input logic [31:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) mem[a + 32'(k)] = w[8*k +: 8];
  endtask

  always @(posedge clk) begin
    acc_t e;
    if (!rst) begin
      mem_done <= 1'b0;
      cnt      <= 0;
      prev_req <= 1'b0;
    end else begin
      if ((mem_rd_req || mem_wr_req) && !prev_req && mem_done) viol <= viol + 1;
      if (mem_rd_req && mem_wr_req) viol <= viol + 1;
      if ((mem_rd_req || mem_wr_req) && prev_req &&
          {mem_addr, mem_data_mask, mem_data_out} != prev_bus) viol <= viol + 1;
      prev_req <= mem_rd_req || mem_wr_req;
      prev_bus <= {mem_addr, mem_data_mask, mem_data_out};
      if (mem_rd_req || mem_wr_req) begin
        if (!mem_done) begin
          if (cnt == 1) begin
            if (mem_wr_req) begin
              for (int k = 0; k < 4; k++)
                if (mem_data_mask[k]) mem[mem_addr + 32'(k)] = mem_data_out[8*k +: 8];
            end else begin
              mem_data_in <= rd_word(mem_addr);
            end
            e.we = mem_wr_req; e.a = mem_addr; e.m = mem_data_mask; e.d = mem_data_out;
            log_q.push_back(e);
            mem_done <= 1'b1;
            cnt      <= 0;
          end else begin
            cnt <= cnt + 1;
          end
        end
      end else begin
        mem_done <= 1'b0;
        cnt      <= 0;
      end
    end
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic chk_acc(input string tag, input int idx, input logic we,
                         input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    if (idx >= log_q.size()) begin
      chk({tag, "_present"}, 32'(log_q.size()), 32'(idx + 1));
    end else begin
      chk({tag, "_we"},   32'(log_q[idx].we), 32'(we));
      chk({tag, "_addr"}, log_q[idx].a, a);
      chk({tag, "_mask"}, 32'(log_q[idx].m), 32'(m));
      if (we) chk({tag, "_data"}, log_q[idx].d, d);
    end
  endtask

  task automatic run_op(input string tag, input logic st, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd_o, output logic flt, output int lat);
    logic got;
    repeat (3) @(posedge clk);
    #1;
    is_store = st; size = sz; is_unsigned = uns; addr = a; wdata = wd; req = 1'b1;
    got = 1'b0; lat = 0; rd_o = 'x; flt = 'x;
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) begin got = 1'b1; rd_o = rdata; flt = fault; end
    end
    req = 1'b0;
    if (!got) chk({tag, "_timeout"}, 32'd0, 32'd1);
    else begin
      @(posedge clk); #1;
      chk({tag, "_pulse"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] r;
    logic        f;
    int          lat, l0, pulses;
    logic        found;

    rst = 1'b0; rst_nf = 1'b0; req = 1'b0; req_nf = 1'b0;
    is_store = 1'b0; size = 2'd0; is_unsigned = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req",   {30'd0, mem_rd_req, mem_wr_req}, 32'd0);
    chk("rst_done",  {30'd0, done, fault}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_addr",  mem_addr, 32'd0);
    chk("rst_dout",  mem_data_out, 32'd0);
    chk("rst_mask",  32'(mem_data_mask), 32'd0);
    rst = 1'b1;

    // 1: store byte
    l0 = log_q.size();
    run_op("t1", 1'b1, 2'd0, 1'b0, 32'h0000_1003, 32'h0000_00A5, r, f, lat);
    chk("t1_fault", 32'(f), 32'd0);
    chk("t1_lat", 32'(lat), 32'd4);
    chk("t1_n", 32'(log_q.size() - l0), 32'd1);
    chk_acc("t1_a0", l0, 1'b1, 32'h0000_1000, 4'b1000, 32'hA500_0000);

    // 2: half loads signed/unsigned
    put_word(32'h0000_2000, 32'h8001_7FFF);
    l0 = log_q.size();
    run_op("t2s", 1'b0, 2'd1, 1'b0, 32'h0000_2002, 32'h0, r, f, lat);
    chk("t2s_rdata", r, 32'hFFFF_8001);
    chk("t2s_lat", 32'(lat), 32'd4);
    chk_acc("t2s_a0", l0, 1'b0, 32'h0000_2000, 4'b1100, 32'h0);
    run_op("t2u", 1'b0, 2'd1, 1'b1, 32'h0000_2002, 32'h0, r, f, lat);
    chk("t2u_rdata", r, 32'h0000_8001);
    run_op("t2b", 1'b0, 2'd0, 1'b0, 32'h0000_2003, 32'h0, r, f, lat);
    chk("t2b_rdata", r, 32'hFFFF_FF80);
    run_op("t2bu", 1'b0, 2'd0, 1'b1, 32'h0000_2003, 32'h0, r, f, lat);
    chk("t2bu_rdata", r, 32'h0000_0080);

    // 3: split store word and read-back
    l0 = log_q.size();
    run_op("t3", 1'b1, 2'd2, 1'b0, 32'h0000_3001, 32'h1122_3344, r, f, lat);
    chk("t3_fault", 32'(f), 32'd0);
    chk("t3_rdata", r, 32'd0);
    chk("t3_n", 32'(log_q.size() - l0), 32'd2);
    chk_acc("t3_a0", l0,     1'b1, 32'h0000_3000, 4'b1110, 32'h2233_4400);
    chk_acc("t3_a1", l0 + 1, 1'b1, 32'h0000_3004, 4'b0001, 32'h0000_0011);
    chk("t3_viol", 32'(viol), 32'd0);
    run_op("t3r", 1'b0, 2'd2, 1'b0, 32'h0000_3001, 32'h0, r, f, lat);
    chk("t3r_rdata", r, 32'h1122_3344);

    // 4: split load word; same op faults without splitting
    put_word(32'h0000_4000, 32'hDDCC_BBAA);
    put_word(32'h0000_4004, 32'h0000_00EE);
    l0 = log_q.size();
    run_op("t4", 1'b0, 2'd2, 1'b0, 32'h0000_4002, 32'h0, r, f, lat);
    chk("t4_rdata", r, 32'h00EE_DDCC);
    chk_acc("t4_a0", l0,     1'b0, 32'h0000_4000, 4'b1100, 32'h0);
    chk_acc("t4_a1", l0 + 1, 1'b0, 32'h0000_4004, 4'b0011, 32'h0);
    run_op("t4h", 1'b0, 2'd1, 1'b0, 32'h0000_4003, 32'h0, r, f, lat);
    chk("t4h_rdata", r, 32'hFFFF_EEDD);
    chk_acc("t4h_a0", l0 + 2, 1'b0, 32'h0000_4000, 4'b1000, 32'h0);
    chk_acc("t4h_a1", l0 + 3, 1'b0, 32'h0000_4004, 4'b0001, 32'h0);

    @(posedge clk); #1;
    rst_nf = 1'b1;
    @(posedge clk); #1;
    is_store = 1'b0; size = 2'd2; is_unsigned = 1'b0; addr = 32'h0000_4002; req_nf = 1'b1;
    @(posedge clk); #1;
    chk("t4nf_done", 32'(done_nf), 32'd1);
    chk("t4nf_fault", 32'(fault_nf), 32'd1);
    chk("t4nf_rdata", rdata_nf, 32'd0);
    chk("t4nf_bus", {30'd0, rd_nf, wr_nf}, 32'd0);
    req_nf = 1'b0;
    @(posedge clk); #1;
    chk("t4nf_pulse", 32'(done_nf), 32'd0);
    chk("t4nf_bus2", {30'd0, rd_nf, wr_nf}, 32'd0);

    // 5: illegal size and address wrap
    l0 = log_q.size();
    run_op("t5i", 1'b0, 2'd3, 1'b0, 32'h0000_5000, 32'h0, r, f, lat);
    chk("t5i_fault", 32'(f), 32'd1);
    chk("t5i_rdata", r, 32'd0);
    chk("t5i_lat", 32'(lat), 32'd1);
    run_op("t5s", 1'b1, 2'd3, 1'b0, 32'h0000_5000, 32'hFFFF_FFFF, r, f, lat);
    chk("t5s_fault", 32'(f), 32'd1);
    chk("t5i_nobus", 32'(log_q.size() - l0), 32'd0);
    put_word(32'hFFFF_FFFC, 32'hDDCC_BBAA);
    put_word(32'h0000_0000, 32'h0000_FFEE);
    run_op("t5w", 1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h0, r, f, lat);
    chk("t5w_rdata", r, 32'hFFEE_DDCC);
    chk_acc("t5w_a0", l0,     1'b0, 32'hFFFF_FFFC, 4'b1100, 32'h0);
    chk_acc("t5w_a1", l0 + 1, 1'b0, 32'h0000_0000, 4'b0011, 32'h0);

    // 6: reset during the second access
    repeat (3) @(posedge clk);
    #1;
    is_store = 1'b0; size = 2'd2; is_unsigned = 1'b0; addr = 32'h0000_4002; req = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #1;
      if (mem_rd_req && mem_addr == 32'h0000_4004) found = 1'b1;
    end
    chk("t6_acc1", 32'(found), 32'd1);
    rst = 1'b0; req = 1'b0;
    @(posedge clk); #1;
    chk("t6_req",   {30'd0, mem_rd_req, mem_wr_req}, 32'd0);
    chk("t6_done",  {30'd0, done, fault}, 32'd0);
    chk("t6_rdata", rdata, 32'd0);
    chk("t6_bus",   mem_addr | mem_data_out | 32'(mem_data_mask), 32'd0);
    rst = 1'b1;
    l0 = log_q.size();
    run_op("t6n", 1'b1, 2'd0, 1'b0, 32'h0000_6000, 32'h0000_005A, r, f, lat);
    chk("t6n_lat", 32'(lat), 32'd4);
    chk_acc("t6n_a0", l0, 1'b1, 32'h0000_6000, 4'b0001, 32'h0000_005A);

    // back-to-back ops with req held
    repeat (3) @(posedge clk);
    #1;
    l0 = log_q.size();
    is_store = 1'b1; size = 2'd0; is_unsigned = 1'b0; addr = 32'h0000_7001; wdata = 32'h77;
    req = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40 && pulses < 2; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    req = 1'b0;
    chk("b2b_pulses", 32'(pulses), 32'd2);
    chk("b2b_n", 32'(log_q.size() - l0), 32'd2);
    chk_acc("b2b_a0", l0,     1'b1, 32'h0000_7000, 4'b0010, 32'h0000_7700);
    chk_acc("b2b_a1", l0 + 1, 1'b1, 32'h0000_7000, 4'b0010, 32'h0000_7700);
    repeat (4) @(posedge clk);
    #1;
    chk("viol_total", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
